// File: rtl/cache_line_mover_if.sv
// Bundle of the controller request, data-SRAM and memory-channel signals of cache_line_mover.
// master = the mover itself; slave = the controller/SRAM/memory side that drives it.
interface cache_line_mover_if #(
  parameter int CACHE_SET_BITS  = 2,
  parameter int CACHE_LINE_BITS = 512,
  parameter int BEAT_BITS       = 128
);
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [CACHE_SET_BITS-1:0]  req_set;
  logic                       done;
  logic                       fill_err;
  logic                       sram_we;
  logic [CACHE_SET_BITS-1:0]  sram_addr;
  logic [CACHE_LINE_BITS-1:0] sram_data_in;
  logic [CACHE_LINE_BITS-1:0] sram_data_out;
  logic                       mem_tx_valid;
  logic                       mem_tx_ready;
  logic [BEAT_BITS-1:0]       mem_tx_data;
  logic                       mem_tx_last;
  logic                       mem_rx_valid;
  logic                       mem_rx_ready;
  logic [BEAT_BITS-1:0]       mem_rx_data;

  modport master (
    input  req_valid, req_write, req_set, sram_data_out,
           mem_tx_ready, mem_rx_valid, mem_rx_data,
    output req_ready, done, fill_err, sram_we, sram_addr, sram_data_in,
           mem_tx_valid, mem_tx_data, mem_tx_last, mem_rx_ready
  );

  modport slave (
    output req_valid, req_write, req_set, sram_data_out,
           mem_tx_ready, mem_rx_valid, mem_rx_data,
    input  req_ready, done, fill_err, sram_we, sram_addr, sram_data_in,
           mem_tx_valid, mem_tx_data, mem_tx_last, mem_rx_ready
  );
endinterface

// File: rtl/cache_line_mover.sv
// Moves whole cache lines between the data SRAM and the memory channel (evict / fill).
// Define LINE_MOVER_VERIFY_EN to add a readback check after each fill (sticky fill_err).
module cache_line_mover #(
  parameter int CACHE_SET_BITS  = 2,
  parameter int CACHE_LINE_BITS = 512,
  parameter int BEAT_BITS       = 128
) (
  input  logic               clk,
  input  logic               reset_n,
  cache_line_mover_if.master bus
);
  localparam int BEATS = CACHE_LINE_BITS / BEAT_BITS;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] EV_RD   = 3'd1;
  localparam logic [2:0] EV_CAP  = 3'd2;
  localparam logic [2:0] EV_TX   = 3'd3;
  localparam logic [2:0] FL_RX   = 3'd4;
  localparam logic [2:0] FL_WR   = 3'd5;
`ifdef LINE_MOVER_VERIFY_EN
  localparam logic [2:0] FL_VRD  = 3'd6;
  localparam logic [2:0] FL_VCMP = 3'd7;
`endif

  logic [2:0]                 state;
  logic [2:0]                 state_nxt;
  logic [CACHE_SET_BITS-1:0]  set_q;
  logic [CNT_W-1:0]           cnt;
  logic [CACHE_LINE_BITS-1:0] line_buf;
  logic                       done_q;
  logic                       finish;
  logic                       accept;
  logic                       tx_fire;
  logic                       rx_fire;
  logic [BEAT_BITS-1:0]       tx_beat;

  assign accept  = (state == IDLE) && bus.req_valid;
  assign tx_fire = (state == EV_TX) && bus.mem_tx_ready;
  assign rx_fire = (state == FL_RX) && bus.mem_rx_valid;

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = bus.req_write ? FL_RX : EV_RD;
      EV_RD:   state_nxt = EV_CAP;
      EV_CAP:  state_nxt = EV_TX;
      EV_TX:   if (tx_fire && cnt == LAST_CNT) begin
                 state_nxt = IDLE;
                 finish    = 1'b1;
               end
      FL_RX:   if (rx_fire && cnt == LAST_CNT) state_nxt = FL_WR;
`ifdef LINE_MOVER_VERIFY_EN
      FL_WR:   state_nxt = FL_VRD;
      FL_VRD:  state_nxt = FL_VCMP;
      FL_VCMP: begin
                 state_nxt = IDLE;
                 finish    = 1'b1;
               end
`else
      FL_WR:   begin
                 state_nxt = IDLE;
                 finish    = 1'b1;
               end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Evict beat mux: beat k is line[k*BEAT_BITS +: BEAT_BITS], beat 0 first.
  always_comb begin
    tx_beat = '0;
    for (int k = 0; k < BEATS; k++)
      if (cnt == CNT_W'(k)) tx_beat = line_buf[k*BEAT_BITS +: BEAT_BITS];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      set_q    <= '0;
      cnt      <= '0;
      line_buf <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= finish;
      if (accept) begin
        set_q <= bus.req_set;
        cnt   <= '0;
      end else if (state == EV_CAP) begin
        line_buf <= bus.sram_data_out;
        cnt      <= '0;
      end else if (tx_fire) begin
        cnt <= cnt + CNT_W'(1);
      end else if (rx_fire) begin
        for (int k = 0; k < BEATS; k++)
          if (cnt == CNT_W'(k)) line_buf[k*BEAT_BITS +: BEAT_BITS] <= bus.mem_rx_data;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef LINE_MOVER_VERIFY_EN
  logic fill_err_q;

  // Sticky until reset: any readback mismatch after a fill is reported.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      fill_err_q <= 1'b0;
    else if (state == FL_VCMP && bus.sram_data_out != line_buf)
      fill_err_q <= 1'b1;
  end

  assign bus.fill_err = fill_err_q;
`else
  assign bus.fill_err = 1'b0;
`endif

  // Strobes decode straight from state so a reset kills them in the same instant.
  assign bus.req_ready    = (state == IDLE);
  assign bus.done         = done_q;
  assign bus.sram_we      = (state == FL_WR);
  assign bus.sram_addr    = set_q;
  assign bus.sram_data_in = line_buf;
  assign bus.mem_tx_valid = (state == EV_TX);
  assign bus.mem_tx_data  = tx_beat;
  assign bus.mem_tx_last  = (state == EV_TX) && (cnt == LAST_CNT);
  assign bus.mem_rx_ready = (state == FL_RX);
endmodule

// File: tb/tb_cache_line_mover.sv
// Directed bench for cache_line_mover with a behavioural 1-cycle-read SRAM model.
// Define LINE_MOVER_VERIFY_EN for both DUT and bench to exercise the readback check.
module tb_cache_line_mover;
  localparam int SB = 2;
  localparam int LB = 512;
  localparam int BB = 128;
  localparam logic [LB-1:0] CORRUPT_MASK = 512'd1 << 5;

  logic clk;
  logic reset_n;
  cache_line_mover_if #(.CACHE_SET_BITS(SB), .CACHE_LINE_BITS(LB), .BEAT_BITS(BB)) bus ();

  cache_line_mover #(.CACHE_SET_BITS(SB), .CACHE_LINE_BITS(LB), .BEAT_BITS(BB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: synchronous write, registered read; preload port for the bench.
  logic [LB-1:0] sram_mem [4];
  logic          preload_en;
  logic [SB-1:0] preload_addr;
  logic [LB-1:0] preload_data;
  logic          corrupt;
  int            we_cnt = 0;

  always @(posedge clk) begin
    if (preload_en) sram_mem[preload_addr] <= preload_data;
    else if (bus.sram_we) sram_mem[bus.sram_addr] <= corrupt ? (bus.sram_data_in ^ CORRUPT_MASK) : bus.sram_data_in;
    bus.sram_data_out <= sram_mem[bus.sram_addr];
    if (bus.sram_we) we_cnt <= we_cnt + 1;
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [SB-1:0] set);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_set   = set;
    tick();
    bus.req_valid = 1'b0;
  endtask

  logic [LB-1:0] line_l;
  logic [LB-1:0] line_f;
  logic [BB-1:0] fbeat [4];
  int            we_before;

  initial begin
    for (int k = 0; k < 4; k++) line_l[k*BB +: BB] = {4{32'hC0DE_0000 + 32'(k)}};
    fbeat[0] = {32{4'hA}};
    fbeat[1] = {32{4'hB}};
    fbeat[2] = {32{4'hC}};
    fbeat[3] = {32{4'hD}};
    line_f = {fbeat[3], fbeat[2], fbeat[1], fbeat[0]};

    reset_n          = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_set      = '0;
    bus.mem_tx_ready = 1'b0;
    bus.mem_rx_valid = 1'b0;
    bus.mem_rx_data  = '0;
    preload_en       = 1'b0;
    preload_addr     = '0;
    preload_data     = '0;
    corrupt          = 1'b0;
    #1;
    check("rst_req_ready", LB'(bus.req_ready), LB'(1));
    check("rst_ctrl", LB'({bus.done, bus.sram_we, bus.mem_tx_valid, bus.mem_tx_last, bus.mem_rx_ready, bus.fill_err}), '0);
    check("rst_addr", LB'(bus.sram_addr), '0);
    check("rst_buf", bus.sram_data_in, '0);
    tick();
    tick();
    reset_n = 1'b1;
    preload_en   = 1'b1;
    preload_addr = 2'd2;
    preload_data = line_l;
    tick();
    preload_en = 1'b0;

    // Evict set 2, tx ready held high: beats at cycles 3..6, done at 7
    bus.mem_tx_ready = 1'b1;
    check("t1_req_ready", LB'(bus.req_ready), LB'(1));
    issue(1'b0, 2'd2);
    check("t1_busy", LB'(bus.req_ready), '0);
    check("t1_addr", LB'(bus.sram_addr), LB'(2));
    tick();
    check("t1_no_beat_cap", LB'(bus.mem_tx_valid), '0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t1_valid", LB'(bus.mem_tx_valid), LB'(1));
      check("t1_data", LB'(bus.mem_tx_data), LB'(line_l[k*BB +: BB]));
      check("t1_last", LB'(bus.mem_tx_last), LB'(k == 3));
      check("t1_no_done", LB'(bus.done), '0);
      tick();
    end
    check("t1_done", LB'({bus.done, bus.req_ready, bus.mem_tx_valid}), LB'(3'b110));
    tick();
    check("t1_done_pulse", LB'(bus.done), '0);

    // Evict with tx ready low for 3 cycles on beat 1
    issue(1'b0, 2'd2);
    tick();
    tick();
    check("t2_beat0", LB'(bus.mem_tx_data), LB'(line_l[0 +: BB]));
    tick();
    bus.mem_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_valid", LB'({bus.mem_tx_valid, bus.mem_tx_last}), LB'(2'b10));
      check("t2_hold_data", LB'(bus.mem_tx_data), LB'(line_l[BB +: BB]));
      tick();
    end
    bus.mem_tx_ready = 1'b1;
    check("t2_beat1", LB'(bus.mem_tx_data), LB'(line_l[BB +: BB]));
    tick();
    check("t2_beat2", LB'(bus.mem_tx_data), LB'(line_l[2*BB +: BB]));
    tick();
    check("t2_beat3", LB'({bus.mem_tx_last, bus.mem_tx_data}), LB'({1'b1, line_l[3*BB +: BB]}));
    tick();
    check("t2_done", LB'(bus.done), LB'(1));

    // Fill set 1 with gapped beats while req_valid stays high for a following evict
    we_before = we_cnt;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_set   = 2'd1;
    tick();
    bus.req_write = 1'b0;
    check("t4_busy", LB'({bus.req_ready, bus.mem_rx_ready}), LB'(2'b01));
    for (int k = 0; k < 4; k++) begin
      bus.mem_rx_valid = 1'b0;
      tick();
      tick();
      check("t3_rx_ready", LB'(bus.mem_rx_ready), LB'(1));
      bus.mem_rx_valid = 1'b1;
      bus.mem_rx_data  = fbeat[k];
      tick();
    end
    bus.mem_rx_valid = 1'b0;
    check("t3_we", LB'({bus.sram_we, bus.req_ready, bus.done}), LB'(3'b100));
    check("t3_wdata", bus.sram_data_in, line_f);
    check("t3_waddr", LB'(bus.sram_addr), LB'(1));
`ifdef LINE_MOVER_VERIFY_EN
    tick();
    check("t3_vrd_no_we", LB'({bus.sram_we, bus.done}), '0);
    tick();
    check("t3_vcmp_no_done", LB'(bus.done), '0);
`endif
    tick();
    check("t4_done_accept", LB'({bus.done, bus.req_ready}), LB'(2'b11));
    check("t3_single_we", LB'(we_cnt - we_before), LB'(1));
    tick();
    bus.req_valid = 1'b0;
    check("t4_b2b_busy", LB'({bus.req_ready, bus.done}), '0);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t3_readback", LB'(bus.mem_tx_data), LB'(fbeat[k]));
      tick();
    end
    check("t3_rb_done", LB'(bus.done), LB'(1));
    check("t3_no_err", LB'(bus.fill_err), '0);

    // Reset mid-evict after beat 1, then restart from beat 0
    issue(1'b0, 2'd2);
    tick();
    tick();
    tick();
    tick();
    check("t5_pre_beat2", LB'(bus.mem_tx_data), LB'(line_l[2*BB +: BB]));
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_ctrl", LB'({bus.mem_tx_valid, bus.mem_tx_last, bus.done, bus.sram_we, bus.mem_rx_ready}), '0);
    check("t5_rst_ready", LB'(bus.req_ready), LB'(1));
    check("t5_rst_buf", bus.sram_data_in, '0);
    check("t5_rst_addr", LB'(bus.sram_addr), '0);
    tick();
    reset_n = 1'b1;
    check("t5_idle", LB'({bus.mem_tx_valid, bus.req_ready}), LB'(2'b01));
    issue(1'b0, 2'd2);
    tick();
    tick();
    check("t5_restart", LB'({bus.mem_tx_valid, bus.mem_tx_data}), LB'({1'b1, line_l[0 +: BB]}));
    repeat (4) tick();
    check("t5_done", LB'(bus.done), LB'(1));

`ifdef LINE_MOVER_VERIFY_EN
    // Corrupting SRAM: readback mismatch sets a sticky fill_err
    corrupt = 1'b1;
    bus.mem_rx_valid = 1'b1;
    bus.mem_rx_data  = fbeat[0];
    issue(1'b1, 2'd0);
    for (int k = 0; k < 4; k++) begin
      bus.mem_rx_data = fbeat[k];
      tick();
    end
    bus.mem_rx_valid = 1'b0;
    check("t6_we", LB'({bus.sram_we, bus.fill_err}), LB'(2'b10));
    tick();
    tick();
    check("t6_vcmp_pre", LB'(bus.fill_err), '0);
    tick();
    check("t6_err_set", LB'({bus.done, bus.fill_err}), LB'(2'b11));
    corrupt = 1'b0;
    repeat (3) tick();
    check("t6_err_sticky", LB'(bus.fill_err), LB'(1));
`else
    check("t6_err_tied", LB'(bus.fill_err), '0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
